// File: rtl/mem_arbiter_pkg.sv
// Shared memory-port definitions: address type, memory geometry and command record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int MEM_SIZE  = 1024;   // memory words
    localparam int MEM_REQS  = 4;      // requesters sharing the memory port
    localparam int MEM_WORD  = 32;     // bits per memory word
    localparam int MEM_BLOCK = 4;      // words per block transfer

    typedef logic [$clog2(MEM_SIZE)-1:0] addr_t;

    // Command record at the default memory geometry, for blocks that talk to the arbiter.
    typedef struct packed {
        logic                                 we;
        addr_t                                addr;
        logic [MEM_BLOCK-1:0][MEM_WORD-1:0]   wdata;
        logic [$clog2(MEM_BLOCK):0]           wr_size;
        logic [$clog2(MEM_REQS)-1:0]          id;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the memory arbiter.
// Latency: n/a (wires only).
// Backpressure: none; o_gnt is the only accept signal, requests wait for it.
// Ports: slave = arbiter view, master = requesters + memory view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ       = MEM_REQS,
    parameter int SIZE       = MEM_WORD,
    parameter int BLOCK_SIZE = MEM_BLOCK,
    parameter int ADDR_SIZE  = $bits(addr_t)
);
    localparam int IDXW = $clog2(NREQ);
    localparam int WSW  = $clog2(BLOCK_SIZE) + 1;

    // requester side
    logic [NREQ-1:0]                             i_req;
    logic [NREQ-1:0]                             i_we;
    logic [NREQ-1:0][ADDR_SIZE-1:0]              i_addr;
    logic [NREQ-1:0][BLOCK_SIZE-1:0][SIZE-1:0]   i_wdata;
    logic [NREQ-1:0][WSW-1:0]                    i_wr_size;
    logic [NREQ-1:0]                             o_gnt;
    logic                                        o_rvalid;
    logic [IDXW-1:0]                             o_rid;
    logic [BLOCK_SIZE-1:0][SIZE-1:0]             o_rdata;
    logic                                        o_err;
    logic [IDXW-1:0]                             o_err_id;

    // memory side
    logic [ADDR_SIZE-1:0]                        o_mem_addr_w;
    logic [BLOCK_SIZE-1:0][SIZE-1:0]             o_mem_data_w;
    logic [WSW-1:0]                              o_mem_wr_size;
    logic                                        o_mem_wr_en;
    logic [ADDR_SIZE-1:0]                        o_mem_addr_r;
    logic [BLOCK_SIZE-1:0][SIZE-1:0]             i_mem_rdata;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_wr_size, i_mem_rdata,
        output o_gnt, o_rvalid, o_rid, o_rdata, o_err, o_err_id,
        output o_mem_addr_w, o_mem_data_w, o_mem_wr_size, o_mem_wr_en, o_mem_addr_r
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_wr_size, i_mem_rdata,
        input  o_gnt, o_rvalid, o_rid, o_rdata, o_err, o_err_id,
        input  o_mem_addr_w, o_mem_data_w, o_mem_wr_size, o_mem_wr_en, o_mem_addr_r
    );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin grant among NREQ requesters; search starts at a rotating pointer.
// Latency: grant is combinational in the request cycle; pointer moves at the closing edge.
// Backpressure: none; an unserved request simply waits for the search to reach it.
// Ports: clk, rst (async, active-high), req in, gnt one-hot out, gnt_idx/gnt_vld out.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] cand;

    // First set request at or above the pointer, wrapping; nothing is granted in reset.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cand = IDXW'((int'(ptr_q) + i) % NREQ);
                if (!gnt_vld && req[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (gnt_vld) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    // Winner becomes lowest priority next cycle; pointer holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (gnt_vld) begin
            ptr_q <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-read/block-write memory port among NREQ requesters, round-robin.
// Latency: grant combinational (T), mem access T+1, read data with o_rvalid in T+2.
// Backpressure: none; one command accepted per cycle, requests wait for o_gnt.
// Ports: i_clk, i_rst (async, active-high), bus (requester + memory signals, slave view).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ       = MEM_REQS,
    parameter int SIZE       = MEM_WORD,
    parameter int BLOCK_SIZE = MEM_BLOCK,
    parameter int DEPTH      = MEM_SIZE,
    parameter int ADDR_SIZE  = $bits(addr_t)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus
);

    localparam int IDXW = $clog2(NREQ);
    localparam int WSW  = $clog2(BLOCK_SIZE) + 1;
    // Wide enough that base + last-word offset can never wrap.
    localparam int BW   = ADDR_SIZE + $clog2(BLOCK_SIZE * SIZE) + 1;
    localparam logic [BW-1:0] LAST_OFS = BW'((BLOCK_SIZE - 1) * SIZE);
    localparam logic [BW-1:0] DEPTH_W  = BW'(DEPTH);

    typedef struct packed {
        logic                            we;
        logic [ADDR_SIZE-1:0]            addr;
        logic [BLOCK_SIZE-1:0][SIZE-1:0] wdata;
        logic [WSW-1:0]                  wr_size;
        logic [IDXW-1:0]                 id;
    } cmd_t;

    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_vld;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (i_clk),
        .rst     (i_rst),
        .req     (bus.i_req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign bus.o_gnt = gnt;

    // Winner's command, size clamped, plus its bounds check.
    cmd_t            sel_cmd;
    logic [BW-1:0]   sel_last;
    logic            sel_in_range;

    always_comb begin
        sel_cmd       = '0;
        sel_cmd.we    = bus.i_we[gnt_idx];
        sel_cmd.addr  = bus.i_addr[gnt_idx];
        sel_cmd.wdata = bus.i_wdata[gnt_idx];
        sel_cmd.wr_size = (bus.i_wr_size[gnt_idx] > WSW'(BLOCK_SIZE)) ?
                          WSW'(BLOCK_SIZE) : bus.i_wr_size[gnt_idx];
        sel_cmd.id    = gnt_idx;
        sel_last      = BW'(sel_cmd.addr) + LAST_OFS;
        sel_in_range  = sel_last < DEPTH_W;
    end

    // Command register: valid for exactly the cycle after its grant.
    cmd_t cmd_q;
    logic cmd_vld_q;
    logic in_range_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cmd_q      <= '0;
            cmd_vld_q  <= 1'b0;
            in_range_q <= 1'b0;
        end else begin
            cmd_vld_q <= gnt_vld;
            if (gnt_vld) begin
                cmd_q      <= sel_cmd;
                in_range_q <= sel_in_range;
            end
        end
    end

    // Enables come straight off the command flops, so reset kills an uncommitted write at once.
    logic wr_issue;
    logic rd_issue;

    assign wr_issue = cmd_vld_q && cmd_q.we && in_range_q && (cmd_q.wr_size != '0);
    assign rd_issue = cmd_vld_q && !cmd_q.we && in_range_q;

    assign bus.o_mem_wr_en   = wr_issue;
    assign bus.o_mem_addr_w  = cmd_q.addr;
    assign bus.o_mem_data_w  = cmd_q.wdata;
    assign bus.o_mem_wr_size = cmd_q.wr_size;
    assign bus.o_mem_addr_r  = cmd_q.addr;
    assign bus.o_err         = cmd_vld_q && !in_range_q;
    assign bus.o_err_id      = cmd_q.id;

    // Read response stage; data holds between pulses.
    logic                            rvalid_q;
    logic [IDXW-1:0]                 rid_q;
    logic [BLOCK_SIZE-1:0][SIZE-1:0] rdata_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_issue;
            if (rd_issue) begin
                rid_q   <= cmd_q.id;
                rdata_q <= bus.i_mem_rdata;
            end
        end
    end

    assign bus.o_rvalid = rvalid_q;
    assign bus.o_rid    = rid_q;
    assign bus.o_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural block memory.
// Latency: expects read data two cycles after grant, errors one cycle after grant.
// Backpressure: none exercised beyond requesters waiting for o_gnt.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NREQ  = 4;
    localparam int SIZE  = 32;
    localparam int BS    = 4;
    localparam int DEPTH = 1024;

    typedef logic [BS-1:0][SIZE-1:0] blk_t;
    typedef struct {
        int   id;
        blk_t data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    rd_exp_t rdq[$];
    int      errq[$];
    rd_exp_t mon_e;
    int      mon_id;
    blk_t    last_rdata = '0;

    // ---------------- memory model ----------------
    logic [SIZE-1:0] mem [0:DEPTH-1];
    int wa;

    function automatic logic [SIZE-1:0] init_word(input int a);
        for (int j = 0; j < BS; j++) begin
            if (a == 16 + j * 32)  return 32'(j + 1);
            if (a == 927 + j * 32) return 32'h900 + 32'(j);
        end
        return '0;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= init_word(a);
        end else if (bus.o_mem_wr_en) begin
            for (int j = 0; j < BS; j++) begin
                if (j < int'(bus.o_mem_wr_size)) begin
                    wa = int'(bus.o_mem_addr_w) + j * SIZE;
                    if (wa < DEPTH) mem[wa[9:0]] <= bus.o_mem_data_w[j];
                end
            end
        end
    end

    for (genvar j = 0; j < BS; j++) begin : g_rd
        int ra;
        assign ra = int'(bus.o_mem_addr_r) + j * SIZE;
        assign bus.i_mem_rdata[j] = (ra < DEPTH) ? mem[ra[9:0]] : '0;
    end

    // ---------------- helpers ----------------
    function automatic blk_t mk(input logic [31:0] w0, w1, w2, w3);
        blk_t b;
        b[0] = w0; b[1] = w1; b[2] = w2; b[3] = w3;
        return b;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_rd(input int id, input blk_t d);
        rdq.push_back('{id: id, data: d});
    endtask

    // Drive one requester for one cycle, check its grant, release after the edge.
    task automatic issue(input int k, input logic we, input logic [9:0] addr,
                         input blk_t wd, input logic [2:0] sz);
        bus.i_we[k]      = we;
        bus.i_addr[k]    = addr;
        bus.i_wdata[k]   = wd;
        bus.i_wr_size[k] = sz;
        bus.i_req        = '0;
        bus.i_req[k]     = 1'b1;
        @(negedge clk);
        check($sformatf("gnt_req%0d", k), bus.o_gnt, 4'b0001 << k);
        @(posedge clk); #1;
        bus.i_req = '0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            last_rdata = '0;
        end else begin
            if (bus.o_rvalid) begin
                if (rdq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid: rid %0d rdata %h", bus.o_rid, bus.o_rdata);
                end else begin
                    mon_e = rdq.pop_front();
                    check("rvalid_rid", bus.o_rid, mon_e.id);
                    check("rvalid_rdata", bus.o_rdata, mon_e.data);
                    last_rdata = mon_e.data;
                end
            end else begin
                check("rdata_hold", bus.o_rdata, last_rdata);
            end
            if (bus.o_err) begin
                if (errq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: err_id %0d", bus.o_err_id);
                end else begin
                    mon_id = errq.pop_front();
                    check("err_id", bus.o_err_id, mon_id);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] WA = 32'hA0A0_0001, WB = 32'hB0B0_0002;
    localparam logic [31:0] WC = 32'hC0C0_0003, WD = 32'hD0D0_0004;

    initial begin
        bus.i_req     = '0;
        bus.i_we      = '0;
        bus.i_wdata   = '0;
        bus.i_wr_size = '0;
        for (int k = 0; k < NREQ; k++) bus.i_addr[k] = 10'd16;

        // Reset state, with every requester already asking.
        repeat (3) @(posedge clk);
        #1;
        preload   = 1'b0;
        bus.i_req = '1;
        #1;
        check("rst_gnt", bus.o_gnt, 4'b0000);
        check("rst_rvalid", bus.o_rvalid, 1'b0);
        check("rst_rid", bus.o_rid, 2'd0);
        check("rst_rdata", bus.o_rdata, '0);
        check("rst_err", {bus.o_err, bus.o_err_id}, 3'b000);
        check("rst_mem_wr", {bus.o_mem_wr_en, bus.o_mem_wr_size, bus.o_mem_addr_w}, '0);
        check("rst_mem_rd", {bus.o_mem_addr_r, bus.o_mem_data_w}, '0);

        // Contention: all four held from reset release, grants rotate 0,1,2,3,0,...
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("rr_cycle%0d", c), bus.o_gnt, 4'b0001 << (c % 4));
            push_rd(c % 4, mk(1, 2, 3, 4));
            @(posedge clk); #1;
        end
        bus.i_req = '0;
        repeat (3) @(posedge clk);
        #1;

        // Single read by requester 1 with exact latency.
        issue(1, 1'b0, 10'd16, '0, 3'd0);
        push_rd(1, mk(1, 2, 3, 4));
        @(negedge clk);
        check("rd_lat_t1", bus.o_rvalid, 1'b0);
        @(negedge clk);
        check("rd_lat_t2", bus.o_rvalid, 1'b1);
        @(posedge clk); #1;

        // Pointer now 2: with req0/req1 pending the search wraps to 0 first.
        bus.i_we    = '0;
        bus.i_addr[0] = 10'd16;
        bus.i_addr[1] = 10'd16;
        bus.i_req   = 4'b0011;
        @(negedge clk);
        check("rr_wrap", bus.o_gnt, 4'b0001);
        push_rd(0, mk(1, 2, 3, 4));
        @(posedge clk); #1;
        bus.i_req = 4'b0010;
        @(negedge clk);
        check("rr_held", bus.o_gnt, 4'b0010);
        push_rd(1, mk(1, 2, 3, 4));
        @(posedge clk); #1;
        bus.i_req = '0;

        // Write then immediate read of the same block.
        issue(0, 1'b1, 10'd0, mk(WA, WB, WC, WD), 3'd4);
        check("wr_en_full", {bus.o_mem_wr_en, bus.o_mem_wr_size}, {1'b1, 3'd4});
        issue(2, 1'b0, 10'd0, '0, 3'd0);
        push_rd(2, mk(WA, WB, WC, WD));

        // Partial write of two words over {1,2,3,4}.
        issue(1, 1'b1, 10'd16, mk(32'hE0, 32'hE1, 32'hE2, 32'hE3), 3'd2);
        issue(3, 1'b0, 10'd16, '0, 3'd0);
        push_rd(3, mk(32'hE0, 32'hE1, 3, 4));

        // Size 0 changes nothing.
        issue(1, 1'b1, 10'd16, mk(32'hF0, 32'hF1, 32'hF2, 32'hF3), 3'd0);
        check("wr_size0_no_en", bus.o_mem_wr_en, 1'b0);
        issue(3, 1'b0, 10'd16, '0, 3'd0);
        push_rd(3, mk(32'hE0, 32'hE1, 3, 4));

        // Oversized write is clamped to a full block.
        issue(0, 1'b1, 10'd0, mk(32'hC0, 32'hC1, 32'hC2, 32'hC3), 3'd7);
        check("wr_size_clamp", {bus.o_mem_wr_en, bus.o_mem_wr_size}, {1'b1, 3'd4});
        issue(2, 1'b0, 10'd0, '0, 3'd0);
        push_rd(2, mk(32'hC0, 32'hC1, 32'hC2, 32'hC3));

        // Bounds: 927 + 96 = 1023 fits, 928 + 96 = 1024 does not.
        issue(2, 1'b0, 10'd927, '0, 3'd0);
        push_rd(2, mk(32'h900, 32'h901, 32'h902, 32'h903));
        issue(2, 1'b0, 10'd928, '0, 3'd0);
        errq.push_back(2);
        issue(1, 1'b1, 10'd928, mk(1, 1, 1, 1), 3'd4);
        errq.push_back(1);
        check("oob_no_wr", bus.o_mem_wr_en, 1'b0);
        issue(1, 1'b1, 10'd927, mk(32'h77, 32'h78, 32'h79, 32'h7A), 3'd4);
        check("edge_wr_en", bus.o_mem_wr_en, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Reset in the cycle after a write grant: the write must not land.
        issue(0, 1'b1, 10'd0, mk(32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD), 3'd4);
        rst = 1'b1;
        #1;
        check("midrst_wr_en", bus.o_mem_wr_en, 1'b0);
        check("midrst_outs", {bus.o_gnt, bus.o_rvalid, bus.o_rid, bus.o_err, bus.o_err_id}, '0);
        check("midrst_mem_bus", {bus.o_mem_addr_w, bus.o_mem_data_w, bus.o_mem_wr_size}, '0);
        check("midrst_rdata", bus.o_rdata, '0);
        @(posedge clk); #1;
        check("midrst_mem0", mem[0], 32'hC0);
        check("midrst_mem96", mem[96], 32'hC3);
        rst = 1'b0;
        issue(2, 1'b0, 10'd0, '0, 3'd0);
        push_rd(2, mk(32'hC0, 32'hC1, 32'hC2, 32'hC3));
        repeat (3) @(posedge clk);
        #1;

        // Reset in the cycle after a read grant: no response may follow.
        issue(3, 1'b0, 10'd16, '0, 3'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        check("rdq_empty", rdq.size(), 0);
        check("errq_empty", errq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
